// File: rtl/fish_pkg.sv
// Shared constants and types for the player-fish motion logic.
package fish_pkg;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    VEL  = 2'd1,
    POS  = 2'd2
  } motion_state_t;

endpackage

// File: rtl/user_axis.sv
// One axis of player motion: signed velocity with accel/friction and a
// position clamped so the whole sprite stays on screen.
module user_axis
  import fish_pkg::*;
#(
  parameter int P_MIN   = 0,
  parameter int P_MAX   = 639,
  parameter int P_START = 320,
  parameter int ACCEL   = 1,
  parameter int VMAX    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_vel,
  input  logic              step_pos,
  input  logic              dir_pos,
  input  logic              dir_neg,
  input  logic [9:0]        size,
  input  logic              respawn,
  input  logic              exist,
  output logic [9:0]        pos,
  output logic signed [4:0] vel_next
);

  localparam logic signed [5:0] ACC_S   = 6'(ACCEL);
  localparam logic signed [5:0] NACC_S  = 6'(-ACCEL);
  localparam logic signed [5:0] VMAX_S  = 6'(VMAX);
  localparam logic signed [5:0] NVMAX_S = 6'(-VMAX);

  logic [9:0]         pos_q, pos_d;
  logic signed [4:0]  vel_q, vel_d;
  logic signed [5:0]  v_ext, v_inc, v_dec;
  logic [9:0]         size_eff;
  logic signed [11:0] nx, lo, hi;

  always_comb begin
    v_ext    = {vel_q[4], vel_q};
    v_inc    = v_ext + ACC_S;
    v_dec    = v_ext - ACC_S;
    size_eff = (size == 10'd0) ? 10'd1 : size;
    nx       = {2'b00, pos_q} + {{7{vel_q[4]}}, vel_q};
    lo       = 12'(P_MIN);
    hi       = 12'(P_MAX + 1) - {2'b00, size_eff};
    // A sprite wider than the screen pins to the low edge.
    if (hi < lo) hi = lo;
    else         hi = hi;

    pos_d = pos_q;
    vel_d = vel_q;
    if (respawn) begin
      pos_d = 10'(P_START);
      vel_d = 5'sd0;
    end else if (step_vel) begin
      if (!exist)                              vel_d = 5'sd0;
      else if (dir_pos)                        vel_d = (v_inc > VMAX_S)  ? 5'(VMAX_S)  : v_inc[4:0];
      else if (dir_neg)                        vel_d = (v_dec < NVMAX_S) ? 5'(NVMAX_S) : v_dec[4:0];
      else if (v_ext <= ACC_S && v_ext >= NACC_S) vel_d = 5'sd0;
      else if (v_ext > 6'sd0)                  vel_d = v_dec[4:0];
      else                                     vel_d = v_inc[4:0];
    end else if (step_pos && exist) begin
      if (nx < lo) begin
        pos_d = lo[9:0];
        vel_d = 5'sd0;
      end else if (nx > hi) begin
        pos_d = hi[9:0];
        vel_d = 5'sd0;
      end else begin
        pos_d = nx[9:0];
      end
    end else begin
      pos_d = pos_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= 10'(P_START);
      vel_q <= 5'sd0;
    end else begin
      pos_q <= pos_d;
      vel_q <= vel_d;
    end
  end

  assign pos      = pos_q;
  assign vel_next = vel_d;

endmodule

// File: rtl/user_motion.sv
// Player-fish motion top: frame_clk synchroniser, WAIT/VEL/POS frame FSM,
// key decode, facing flag and respawn, with one user_axis per screen axis.
module user_motion
  import fish_pkg::*;
#(
  parameter int X_MIN   = 0,
  parameter int X_MAX   = SCREEN_W - 1,
  parameter int Y_MIN   = 0,
  parameter int Y_MAX   = SCREEN_H - 1,
  parameter int X_START = 320,
  parameter int Y_START = 240,
  parameter int ACCEL   = 1,
  parameter int VMAX    = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [9:0] user_sizeX,
  input  logic [9:0] user_sizeY,
  input  logic       user_exist,
  output logic [9:0] user_X,
  output logic [9:0] user_Y,
  output logic       user_facing_left,
  output logic       user_moving,
  output logic       frame_tick
);

  logic [2:0]        sync_q, sync_d;
  logic              tick_q, tick_d;
  logic              exist_q;
  motion_state_t     state_q, state_d;
  logic              facing_q, facing_d;
  logic              moving_q, moving_d;
  logic              respawn, step_vel, step_pos;
  logic signed [4:0] vx_d, vy_d;

  always_comb begin
    sync_d   = {sync_q[1:0], frame_clk};
    tick_d   = sync_q[1] & ~sync_q[2];
    respawn  = user_exist & ~exist_q;
    step_vel = (state_q == VEL);
    step_pos = (state_q == POS);

    case (state_q)
      WAIT:    state_d = tick_q ? VEL : WAIT;
      VEL:     state_d = POS;
      POS:     state_d = WAIT;
      default: state_d = WAIT;
    endcase
    // A tick landing on the respawn cycle is deliberately lost.
    if (respawn) state_d = WAIT;
    else         state_d = state_d;

    facing_d = facing_q;
    if (step_vel && user_exist && !respawn) begin
      if (keycode == KEY_A)      facing_d = 1'b1;
      else if (keycode == KEY_D) facing_d = 1'b0;
      else                       facing_d = facing_q;
    end else begin
      facing_d = facing_q;
    end

    moving_d = (vx_d != 5'sd0) | (vy_d != 5'sd0);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_q   <= 3'b000;
      tick_q   <= 1'b0;
      exist_q  <= 1'b0;
      state_q  <= WAIT;
      facing_q <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      tick_q   <= tick_d;
      exist_q  <= user_exist;
      state_q  <= state_d;
      facing_q <= facing_d;
      moving_q <= moving_d;
    end
  end

  user_axis #(
    .P_MIN(X_MIN), .P_MAX(X_MAX), .P_START(X_START), .ACCEL(ACCEL), .VMAX(VMAX)
  ) u_axis_x (
    .clk      (Clk),
    .rst      (Reset),
    .step_vel (step_vel),
    .step_pos (step_pos),
    .dir_pos  (keycode == KEY_D),
    .dir_neg  (keycode == KEY_A),
    .size     (user_sizeX),
    .respawn  (respawn),
    .exist    (user_exist),
    .pos      (user_X),
    .vel_next (vx_d)
  );

  user_axis #(
    .P_MIN(Y_MIN), .P_MAX(Y_MAX), .P_START(Y_START), .ACCEL(ACCEL), .VMAX(VMAX)
  ) u_axis_y (
    .clk      (Clk),
    .rst      (Reset),
    .step_vel (step_vel),
    .step_pos (step_pos),
    .dir_pos  (keycode == KEY_S),
    .dir_neg  (keycode == KEY_W),
    .size     (user_sizeY),
    .respawn  (respawn),
    .exist    (user_exist),
    .pos      (user_Y),
    .vel_next (vy_d)
  );

  assign user_facing_left = facing_q;
  assign user_moving      = moving_q;
  assign frame_tick       = tick_q;

endmodule

// File: tb/tb_user_motion.sv
// Self-checking bench for user_motion: frame-level reference model driven by
// directed and randomized key/size/exist stimulus.
module tb_user_motion;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [9:0] sx, sy;
  logic       exist;
  logic [9:0] user_X, user_Y;
  logic       user_facing_left, user_moving, frame_tick;

  int n_vec = 0;
  int n_bad = 0;
  int m_x, m_y, m_vx, m_vy;
  bit m_face;

  user_motion dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .user_sizeX(sx), .user_sizeY(sy), .user_exist(exist),
    .user_X(user_X), .user_Y(user_Y), .user_facing_left(user_facing_left),
    .user_moving(user_moving), .frame_tick(frame_tick)
  );

  always #10 Clk = ~Clk;

  initial begin
    #6000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int vel_rule(int v, bit up, bit dn);
    if (up) return (v + 1 > 4) ? 4 : v + 1;
    if (dn) return (v - 1 < -4) ? -4 : v - 1;
    if (v >= -1 && v <= 1) return 0;
    return (v > 0) ? v - 1 : v + 1;
  endfunction

  function automatic void model_reset();
    m_x = 320; m_y = 240; m_vx = 0; m_vy = 0; m_face = 0;
  endfunction

  // One whole frame of the game rules: velocity update, then clamped move.
  function automatic void model_frame();
    int hx, hy, nx, ny;
    if (exist) begin
      m_vx = vel_rule(m_vx, keycode == 8'h07, keycode == 8'h04);
      m_vy = vel_rule(m_vy, keycode == 8'h16, keycode == 8'h1A);
      if (keycode == 8'h04) m_face = 1;
      else if (keycode == 8'h07) m_face = 0;
      hx = 640 - ((sx == 10'd0) ? 1 : int'(sx));
      hy = 480 - ((sy == 10'd0) ? 1 : int'(sy));
      nx = m_x + m_vx;
      ny = m_y + m_vy;
      if (nx < 0) begin m_x = 0; m_vx = 0; end
      else if (nx > hx) begin m_x = hx; m_vx = 0; end
      else m_x = nx;
      if (ny < 0) begin m_y = 0; m_vy = 0; end
      else if (ny > hy) begin m_y = hy; m_vy = 0; end
      else m_y = ny;
    end else begin
      m_vx = 0; m_vy = 0;
    end
  endfunction

  task automatic run_frame(input string tag);
    int cyc;
    @(negedge Clk);
    frame_clk = 1'b1;
    cyc = 0;
    do begin
      @(negedge Clk);
      cyc++;
    end while (frame_tick !== 1'b1 && cyc < 8);
    n_vec++;
    if (cyc !== 3) begin
      n_bad++;
      $display("FAIL %s tick_latency: got %0d cycles, expected 3", tag, cyc);
    end
    repeat (2) begin
      @(negedge Clk);
      n_vec++;
      if ({frame_tick, user_X, user_Y} !== {1'b0, 10'(m_x), 10'(m_y)}) begin
        n_bad++;
        $display("FAIL %s early_update: tick=%0b X=%0d Y=%0d, expected tick=0 X=%0d Y=%0d",
                 tag, frame_tick, user_X, user_Y, m_x, m_y);
      end
    end
    model_frame();
    @(negedge Clk);
    n_vec++;
    if ({user_X, user_Y, user_facing_left, user_moving} !==
        {10'(m_x), 10'(m_y), m_face, ((m_vx != 0) || (m_vy != 0))}) begin
      n_bad++;
      $display("FAIL %s frame_result: X=%0d Y=%0d face=%0b mov=%0b, expected X=%0d Y=%0d face=%0b mov=%0b",
               tag, user_X, user_Y, user_facing_left, user_moving,
               m_x, m_y, m_face, ((m_vx != 0) || (m_vy != 0)));
    end
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1; frame_clk = 1'b0; keycode = 8'h00; sx = 10'd32; sy = 10'd32; exist = 1'b1;
    model_reset();
    #25;
    n_vec++;
    if ({user_X, user_Y, user_facing_left, user_moving, frame_tick} !== {10'd320, 10'd240, 3'b000}) begin
      n_bad++;
      $display("FAIL reset_values: X=%0d Y=%0d face=%0b mov=%0b tick=%0b, expected 320 240 0 0 0",
               user_X, user_Y, user_facing_left, user_moving, frame_tick);
    end
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    n_vec++;
    if ({user_X, user_Y, user_moving, frame_tick} !== {10'd320, 10'd240, 2'b00}) begin
      n_bad++;
      $display("FAIL post_reset_idle: X=%0d Y=%0d mov=%0b tick=%0b, expected 320 240 0 0",
               user_X, user_Y, user_moving, frame_tick);
    end
  endtask

  task automatic test_frame_sync();
    int first, highs;
    first = -1; highs = 0;
    @(negedge Clk);
    frame_clk = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge Clk);
      if (frame_tick === 1'b1) begin
        highs++;
        if (first < 0) first = i;
      end
    end
    model_frame();
    n_vec++;
    if (first !== 3 || highs !== 1) begin
      n_bad++;
      $display("FAIL frame_sync_pulse: first=%0d highs=%0d, expected first=3 highs=1", first, highs);
    end
    frame_clk = 1'b0;
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (frame_tick === 1'b1) highs++;
    end
    n_vec++;
    if (highs !== 0) begin
      n_bad++;
      $display("FAIL frame_sync_fall: pulses=%0d, expected 0", highs);
    end
  endtask

  task automatic test_accel_friction();
    int exp_acc[5] = '{321, 323, 326, 330, 334};
    int exp_fr[5]  = '{337, 339, 340, 340, 340};
    bit exp_mv[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    keycode = 8'h07;
    for (int i = 0; i < 5; i++) begin
      run_frame("accel");
      n_vec++;
      if (user_X !== 10'(exp_acc[i])) begin
        n_bad++;
        $display("FAIL accel_x[%0d]: X=%0d, expected %0d", i, user_X, exp_acc[i]);
      end
    end
    keycode = 8'h00;
    for (int i = 0; i < 5; i++) begin
      run_frame("friction");
      n_vec++;
      if ({user_X, user_moving} !== {10'(exp_fr[i]), exp_mv[i]}) begin
        n_bad++;
        $display("FAIL friction[%0d]: X=%0d mov=%0b, expected X=%0d mov=%0b",
                 i, user_X, user_moving, exp_fr[i], exp_mv[i]);
      end
    end
  endtask

  task automatic test_clamp_edge();
    int k;
    k = 0;
    keycode = 8'h07;
    while (m_x < 606 && k < 200) begin
      run_frame("to_edge");
      k++;
    end
    n_vec++;
    if (user_X !== 10'd606) begin
      n_bad++;
      $display("FAIL edge_approach: X=%0d, expected 606", user_X);
    end
    run_frame("clamp");
    n_vec++;
    if ({user_X, user_moving} !== {10'd608, 1'b0}) begin
      n_bad++;
      $display("FAIL clamp_right: X=%0d mov=%0b, expected X=608 mov=0", user_X, user_moving);
    end
    keycode = 8'h04;
    run_frame("turn_left");
    n_vec++;
    if ({user_X, user_facing_left} !== {10'd607, 1'b1}) begin
      n_bad++;
      $display("FAIL turn_left: X=%0d face=%0b, expected X=607 face=1", user_X, user_facing_left);
    end
  endtask

  task automatic test_exist_and_respawn();
    int cyc;
    @(negedge Clk);
    exist = 1'b0;
    keycode = 8'h07;
    repeat (3) run_frame("dead");
    n_vec++;
    if ({user_X, user_moving} !== {10'd607, 1'b0}) begin
      n_bad++;
      $display("FAIL dead_frozen: X=%0d mov=%0b, expected X=607 mov=0", user_X, user_moving);
    end
    @(negedge Clk);
    frame_clk = 1'b1;
    cyc = 0;
    do begin
      @(negedge Clk);
      cyc++;
    end while (frame_tick !== 1'b1 && cyc < 8);
    n_vec++;
    if (cyc !== 3) begin
      n_bad++;
      $display("FAIL respawn_tick_align: got %0d cycles, expected 3", cyc);
    end
    exist = 1'b1;
    model_reset();
    m_face = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      n_vec++;
      if ({user_X, user_Y, user_moving} !== {10'd320, 10'd240, 1'b0}) begin
        n_bad++;
        $display("FAIL respawn_hold[%0d]: X=%0d Y=%0d mov=%0b, expected 320 240 0",
                 i, user_X, user_Y, user_moving);
      end
    end
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    run_frame("after_respawn");
    n_vec++;
    if (user_X !== 10'd321) begin
      n_bad++;
      $display("FAIL after_respawn_move: X=%0d, expected 321", user_X);
    end
  endtask

  task automatic test_random();
    logic [7:0] keys[6] = '{8'h00, 8'h1A, 8'h04, 8'h16, 8'h07, 8'h2C};
    for (int i = 0; i < 80; i++) begin
      keycode = keys[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) sx = 10'($urandom_range(0, 80));
      if ($urandom_range(0, 3) == 0) sy = 10'($urandom_range(0, 80));
      run_frame("random");
    end
  endtask

  task automatic test_reset_mid_pos();
    int cyc;
    sx = 10'd32; sy = 10'd32;
    keycode = 8'h04;
    repeat (2) run_frame("pre_reset");
    @(negedge Clk);
    frame_clk = 1'b1;
    cyc = 0;
    do begin
      @(negedge Clk);
      cyc++;
    end while (frame_tick !== 1'b1 && cyc < 8);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    frame_clk = 1'b0;
    #1;
    n_vec++;
    if ({user_X, user_Y, user_facing_left, user_moving, frame_tick} !== {10'd320, 10'd240, 3'b000}) begin
      n_bad++;
      $display("FAIL reset_mid_pos: X=%0d Y=%0d face=%0b mov=%0b tick=%0b, expected 320 240 0 0 0",
               user_X, user_Y, user_facing_left, user_moving, frame_tick);
    end
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    repeat (4) @(negedge Clk);
    n_vec++;
    if ({user_X, user_Y, user_moving} !== {10'd320, 10'd240, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_no_partial: X=%0d Y=%0d mov=%0b, expected 320 240 0",
               user_X, user_Y, user_moving);
    end
    keycode = 8'h07;
    run_frame("post_reset_frame");
  endtask

  initial begin
    test_reset();
    test_frame_sync();
    test_accel_friction();
    test_clamp_edge();
    test_exist_and_respawn();
    test_random();
    test_reset_mid_pos();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
